// File: rtl/pool_writeback.sv
// pool_writeback: captures 64-bit pooled words from the max-pool stage and
// queues them in a small FIFO. It writes them to the feature-map SRAM at
// row-strided addresses, so one layer's output lands as NUM_ROWS rows of
// ROW_WORDS words each.
//
// Ports:
//   clk, rst (async, active low)
//   start            one-cycle pulse that begins a layer (ignored unless idle)
//   in_valid/in_data pooled word from upstream; byte 0 is in [7:0]
//   in_ready         word can be accepted this cycle
//   mem_req/mem_addr/mem_wdata/mem_ack  SRAM write port (req held until ack)
//   busy             not idle
//   done             one-cycle pulse after the final write is acked
//   overflow         sticky; a word arrived that could not be accepted
//
// Optional build macro POOL_WB_STATS_EN adds these outputs:
//   wr_count[15:0]     acked writes this layer (saturating)
//   stall_cycles[15:0] cycles with mem_req high and mem_ack low (saturating)
module pool_writeback #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12,
  parameter int BASE_ADDR  = 0,
  parameter int ROW_WORDS  = 7,
  parameter int ROW_STRIDE = 8,
  parameter int NUM_ROWS   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [63:0]       in_data,
  output logic              in_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef POOL_WB_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int TOTAL = ROW_WORDS * NUM_ROWS;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(ROW_WORDS + 1);
  localparam int RW    = $clog2(NUM_ROWS + 1);
  localparam int AW    = $clog2(TOTAL + 1);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [63:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     cnt, rem;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [AW-1:0]   acc_q, acc_inc;
  logic [ADDR_W-1:0] addr_d;
  logic [63:0]     wdata_d;
  logic            push, pop, layer_start, last_push;

  // Handshake and status; all derive from registered state so nothing
  // here depends combinationally on the inputs except push/pop.
  always_comb begin
    in_ready    = (state_q == S_RUN) && (cnt != FULL);
    mem_req     = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (cnt != '0);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    push        = in_valid && in_ready;
    pop         = mem_req && mem_ack;
    layer_start = (state_q == S_IDLE) && start;
    acc_inc     = acc_q + AW'(1);
    last_push   = push && (acc_inc == AW'(TOTAL));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_push) state_d = S_DRAIN;
      S_DRAIN: if (pop && (cnt == ONE)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // row/col track the position of the word currently at the FIFO head.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (layer_start) begin
      row_d = '0;
      col_d = '0;
    end else if (pop) begin
      if (col_q == CW'(ROW_WORDS - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(row_d) * ADDR_W'(ROW_STRIDE)
           + ADDR_W'(col_d);
  end

  // Next head-of-FIFO value. If the FIFO is (or becomes) empty and a word
  // arrives, the new word bypasses storage into the output register so it
  // is presented the very next cycle.
  always_comb begin
    rem     = cnt - {{PW{1'b0}}, pop};
    wdata_d = mem_wdata;
    if (push && (rem == '0))
      wdata_d = in_data;
    else if (pop && (rem != '0))
      wdata_d = fifo_mem[rd_ptr + PW'(1)];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      acc_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + ONE;
      else if (pop && !push) cnt <= cnt - ONE;
      row_q <= row_d;
      col_q <= col_d;
      if (layer_start) acc_q <= '0;
      else if (push)   acc_q <= acc_inc;
      // Address only moves on start or an accepted write, so it is stable
      // for the whole time a request waits for its ack.
      if (layer_start || pop) mem_addr <= addr_d;
      mem_wdata <= wdata_d;
      // A dropped word wins over the clear from start: data was still lost.
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (layer_start)      overflow <= 1'b0;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

`ifdef POOL_WB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count     <= '0;
      stall_cycles <= '0;
    end else if (layer_start) begin
      wr_count     <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop && (wr_count != 16'hFFFF))
        wr_count <= wr_count + 16'd1;
      if (mem_req && !mem_ack && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_writeback.sv
// Directed bench for pool_writeback with default parameters.
module tb_pool_writeback;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, mem_ack;
  logic [63:0]       in_data;
  logic              in_ready, mem_req, busy, done, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
`ifdef POOL_WB_STATS_EN
  logic [15:0]       wr_count, stall_cycles;
`endif

  always #5 clk = ~clk;

  pool_writeback dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .overflow(overflow)
`ifdef POOL_WB_STATS_EN
    , .wr_count(wr_count), .stall_cycles(stall_cycles)
`endif
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic [63:0] data; int cyc; } wr_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [63:0] data; } vec_t;

  wr_t  wr_q[$];
  vec_t vec[49];
  int   tests, fails, cyc, done_cnt, done_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Records the write / done seen in the current cycle, then advances to
  // 1 time unit past the next rising edge.
  task automatic tick();
    wr_t w;
    if (mem_req && mem_ack) begin
      w.addr = mem_addr; w.data = mem_wdata; w.cyc = cyc;
      wr_q.push_back(w);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
    // Expected write stream for a full layer: rows start every 8 words,
    // 7 words per row.
    for (int i = 0; i < 49; i++) begin
      vec[i].addr = ADDR_W'((i / 7) * 8 + (i % 7));
      vec[i].data = 64'(i);
    end

    // ---- reset state
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_busy",     64'(busy),     64'(0));
    chk("rst_mem_req",  64'(mem_req),  64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_done",     64'(done),     64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_wdata",    mem_wdata,     64'(0));
    rst = 1'b1;
    tick();

    // ---- full layer, ack always high
    mem_ack = 1'b1; wr_q.delete(); done_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 49; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      chk("t1_in_ready", 64'(in_ready), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && done_cnt == 0; k++) tick();
    tick(); tick();
    chk("t1_nwrites", 64'(wr_q.size()), 64'(49));
    for (int i = 0; i < 49 && i < wr_q.size(); i++) begin
      chk($sformatf("t1_addr[%0d]", i), 64'(wr_q[i].addr), 64'(vec[i].addr));
      chk($sformatf("t1_data[%0d]", i), wr_q[i].data, vec[i].data);
    end
    chk("t1_done_cnt", 64'(done_cnt), 64'(1));
    if (wr_q.size() == 49)
      chk("t1_done_lat", 64'(done_cyc - wr_q[48].cyc), 64'(1));
    chk("t1_overflow", 64'(overflow), 64'(0));
    chk("t1_idle", 64'(busy), 64'(0));

    // ---- backpressure: ack low, five words back-to-back
    mem_ack = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 64'hA0 + 64'(k);
      chk($sformatf("t2_in_ready[%0d]", k), 64'(in_ready), 64'(k < 4 ? 1 : 0));
      tick();
    end
    in_valid = 1'b0;
    chk("t2_overflow", 64'(overflow), 64'(1));
    for (int k = 0; k < 3; k++) begin
      chk("t2_req_hold",   64'(mem_req),  64'(1));
      chk("t2_addr_hold",  64'(mem_addr), 64'(0));
      chk("t2_wdata_hold", mem_wdata,     64'hA0);
      tick();
    end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("t2_addr_next",  64'(mem_addr), 64'(1));
    chk("t2_wdata_next", mem_wdata,     64'hA1);
    chk("t2_in_ready_after_pop", 64'(in_ready), 64'(1));
    chk("t2_overflow_sticky", 64'(overflow), 64'(1));

    // ---- single word into empty FIFO
    do_reset();
    mem_ack = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_req_empty", 64'(mem_req), 64'(0));
    in_valid = 1'b1; in_data = 64'h5A5A; tick(); in_valid = 1'b0;
    chk("t3_req_t1",   64'(mem_req),  64'(1));
    chk("t3_wdata_t1", mem_wdata,     64'h5A5A);
    chk("t3_addr_t1",  64'(mem_addr), 64'(0));
    tick();
    chk("t3_req_t2", 64'(mem_req), 64'(0));

    // ---- reset mid-layer after 10 acked writes
    do_reset();
    mem_ack = 1'b1; wr_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 64'(100 + i); tick();
    end
    in_valid = 1'b0; tick();
    mem_ack = 1'b0;
    in_valid = 1'b1; in_data = 64'd200; tick();
    in_data = 64'd201; tick();
    in_valid = 1'b0;
    chk("t4_nwrites", 64'(wr_q.size()), 64'(10));
    if (wr_q.size() == 10)
      chk("t4_last_addr", 64'(wr_q[9].addr), 64'(10));
    chk("t4_pending_req", 64'(mem_req), 64'(1));
    rst = 1'b0; #1;
    chk("t4_rst_busy",     64'(busy),     64'(0));
    chk("t4_rst_req",      64'(mem_req),  64'(0));
    chk("t4_rst_in_ready", 64'(in_ready), 64'(0));
    tick(); rst = 1'b1; tick(); tick();
    chk("t4_no_req_after_rst", 64'(mem_req), 64'(0));
    mem_ack = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 64'd300; tick(); in_valid = 1'b0;
    chk("t4_restart_addr",  64'(mem_addr), 64'(0));
    chk("t4_restart_wdata", mem_wdata,     64'd300);
    tick();
    chk("t4_no_stale", 64'(mem_req), 64'(0));

    // ---- in_valid in IDLE, start during RUN
    do_reset();
    in_valid = 1'b1; in_data = 64'd7; tick(); in_valid = 1'b0;
    chk("t5_idle_overflow", 64'(overflow), 64'(1));
    chk("t5_idle_req",      64'(mem_req),  64'(0));
    chk("t5_idle_busy",     64'(busy),     64'(0));
    mem_ack = 1'b1; wr_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_clears_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 64'(400 + i); start = (i == 1);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk("t5_nwrites", 64'(wr_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      chk($sformatf("t5_addr[%0d]", i), 64'(wr_q[i].addr), 64'(i));
      chk($sformatf("t5_data[%0d]", i), wr_q[i].data, 64'(400 + i));
    end
    chk("t5_still_busy", 64'(busy), 64'(1));
    chk("t5_overflow",   64'(overflow), 64'(0));

`ifdef POOL_WB_STATS_EN
    // ---- stats: each write waits 3 cycles before its ack
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 49; i++) begin
      mem_ack = 1'b0;
      in_valid = 1'b1; in_data = 64'(i); tick(); in_valid = 1'b0;
      tick(); tick(); tick();
      mem_ack = 1'b1; tick();
    end
    mem_ack = 1'b0;
    chk("st_done",         64'(done),         64'(1));
    chk("st_wr_count",     64'(wr_count),     64'(49));
    chk("st_stall_cycles", 64'(stall_cycles), 64'(147));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
